// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths and operation codes
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 5;
  localparam int REG_AW = 5;

  typedef enum logic [SEL_W-1:0] {
    SEL_ADD  = 5'b00000,
    SEL_SUB  = 5'b00001,
    SEL_AND  = 5'b00010,
    SEL_OR   = 5'b00011,
    SEL_XOR  = 5'b00100,
    SEL_NOT  = 5'b00101,
    SEL_MUL  = 5'b00110,
    SEL_DIV  = 5'b00111,
    SEL_SHL  = 5'b01000,
    SEL_SHR  = 5'b01001,
    SEL_MOVB = 5'b01010
  } alu_sel_e;

  localparam logic [SEL_W-1:0] SEL_MAX = 5'b01010;

  // Codes above SEL_MAX have no ALU meaning and must never write back.
  function automatic logic sel_is_illegal(input logic [SEL_W-1:0] sel);
    return sel > SEL_MAX;
  endfunction

endpackage

// File: rtl/operand_issue_stage_if.sv
// rtl/operand_issue_stage_if.sv - decoded-instruction handshake into the issue stage
interface operand_issue_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  in_sel;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [REG_AW-1:0] in_rd;
  logic [DATA_W-1:0] in_imm;
  logic              in_use_imm;
  logic              in_wr_en;

  modport master (
    output in_valid, in_sel, in_rs1, in_rs2, in_rd, in_imm, in_use_imm, in_wr_en,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_sel, in_rs1, in_rs2, in_rd, in_imm, in_use_imm, in_wr_en,
    output in_ready
  );

endinterface

// File: rtl/operand_issue_stage_reg_file.sv
// rtl/operand_issue_stage_reg_file.sv - 2R1W register file with hard-zero r0
module reg_file #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic [REG_AW-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd2_data,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int NREGS = 1 << REG_AW;

  logic [DATA_W-1:0] mem [NREGS];

  // Synchronous write port; r0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read ports with r0 forced to zero.
  always_comb begin
    rd1_data = (rd1_addr == '0) ? '0 : mem[rd1_addr];
    rd2_data = (rd2_addr == '0) ? '0 : mem[rd2_addr];
  end

endmodule

// File: rtl/operand_issue_stage.sv
// rtl/operand_issue_stage.sv - operand read/forward, ALU issue register and writeback
module operand_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  operand_issue_stage_if.slave io,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  output logic              alu_valid,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              out_ready,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err_illegal
);

  import alu_pkg::*;

  logic              accept;
  logic              advance;
  logic [REG_AW-1:0] is_rd;
  logic              is_wr_en;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  reg_file #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd1_addr (io.in_rs1),
    .rd1_data (rf_rd1),
    .rd2_addr (io.in_rs2),
    .rd2_data (rf_rd2),
    .wr_en    (wb_valid),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data)
  );

  // A producer in the issue register only releases the slot when it advances.
  assign io.in_ready = !alu_valid || out_ready;
  assign accept      = io.in_valid && io.in_ready;
  assign advance     = alu_valid && out_ready;

  // Newest value wins: ALU result, then writeback, then register file; r0 is always zero.
  function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] rs,
                                            input logic [DATA_W-1:0] rf_val);
    if (rs == '0)                               return '0;
    else if (alu_valid && is_wr_en && is_rd == rs) return alu_f;
    else if (wb_valid && wb_rd == rs)           return wb_data;
    else                                        return rf_val;
  endfunction

  // Operand selection at accept time; immediates bypass forwarding on b.
  always_comb begin
    op_a = fwd(io.in_rs1, rf_rd1);
    op_b = io.in_use_imm ? io.in_imm : fwd(io.in_rs2, rf_rd2);
  end

  // Issue register: load on accept, drain on advance, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      is_rd     <= '0;
      is_wr_en  <= 1'b0;
    end else if (accept) begin
      alu_valid <= 1'b1;
      alu_a     <= op_a;
      alu_b     <= op_b;
      alu_sel   <= io.in_sel;
      is_rd     <= io.in_rd;
      is_wr_en  <= io.in_wr_en && !sel_is_illegal(io.in_sel);
    end else if (advance) begin
      alu_valid <= 1'b0;
    end
  end

  // Writeback register captures the ALU result the cycle it advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= advance && is_wr_en;
      if (advance) begin
        wb_rd   <= is_rd;
        wb_data <= alu_f;
      end
    end
  end

  // Sticky illegal-operation flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
    end else if (accept && sel_is_illegal(io.in_sel)) begin
      err_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_operand_issue_stage.sv
// tb/tb_operand_issue_stage.sv - scoreboard bench for operand_issue_stage
module tb_operand_issue_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_a, alu_b, alu_f, wb_data;
  logic [4:0]  alu_sel, wb_rd;
  logic        alu_valid, out_ready, wb_valid, err_illegal;

  int checks = 0;
  int passed = 0;
  int waits_total = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;
  wb_exp_t exp_q[$];

  operand_issue_stage_if #(.DATA_W(32), .REG_AW(5), .SEL_W(5)) io ();

  operand_issue_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io          (io),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_valid   (alu_valid),
    .alu_f       (alu_f),
    .out_ready   (out_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU for the operations this bench uses.
  always_comb begin
    case (alu_sel)
      SEL_ADD:  alu_f = alu_a + alu_b;
      SEL_SUB:  alu_f = alu_a - alu_b;
      SEL_MOVB: alu_f = alu_b;
      default:  alu_f = 32'h0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every live writeback must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", {27'h0, wb_rd}, 32'hFFFF_FFFF);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", {27'h0, wb_rd}, {27'h0, e.rd});
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  // Present one instruction and return just after the edge that accepts it.
  task automatic issue(input logic [4:0] sel, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] imm, input logic use_imm,
                       input logic wr_en, input logic push, input logic [31:0] exp_data);
    bit ok = 0;
    io.in_sel = sel; io.in_rs1 = rs1; io.in_rs2 = rs2; io.in_rd = rd;
    io.in_imm = imm; io.in_use_imm = use_imm; io.in_wr_en = wr_en;
    io.in_valid = 1'b1;
    if (push) exp_q.push_back({rd, exp_data});
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (io.in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end else begin
        waits_total++;
      end
    end
    if (!ok) chk("accept_timeout", 32'h0, 32'h1);
    io.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    io.in_valid = 0; io.in_sel = 0; io.in_rs1 = 0; io.in_rs2 = 0; io.in_rd = 0;
    io.in_imm = 0; io.in_use_imm = 0; io.in_wr_en = 0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_alu_valid", {31'h0, alu_valid}, 32'h0);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, io.in_ready}, 32'h1);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_err", {31'h0, err_illegal}, 32'h0);
    @(posedge clk); #1;

    // Registers start at zero.
    issue(SEL_MOVB, 5'd0, 5'd1, 5'd2, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    idle(3);

    // Immediate loads then dependent add, forwarding from WB and ALU.
    issue(SEL_MOVB, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 1'b1, 1'b1, 32'd5);
    issue(SEL_MOVB, 5'd0, 5'd0, 5'd2, 32'd7, 1'b1, 1'b1, 1'b1, 32'd7);
    issue(SEL_ADD,  5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b1, 1'b1, 32'd12);
    chk("add_alu_a_from_wb", alu_a, 32'd5);
    chk("add_alu_b_from_alu", alu_b, 32'd7);
    idle(3);

    // Full-rate dependency chain on r3.
    waits_total = 0;
    for (int i = 0; i < 4; i++) begin
      issue(SEL_ADD, 5'd3, 5'd0, 5'd3, 32'd1, 1'b1, 1'b1, 1'b1, 32'd13 + i);
    end
    chk("chain_no_stall", waits_total, 32'd0);
    idle(3);

    // Backpressure holds the issue register.
    issue(SEL_SUB, 5'd3, 5'd0, 5'd3, 32'd2, 1'b1, 1'b1, 1'b1, 32'd14);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'h0, io.in_ready}, 32'h0);
      chk("bp_alu_a", alu_a, 32'd16);
      chk("bp_alu_b", alu_b, 32'd2);
      chk("bp_alu_sel", {27'h0, alu_sel}, {27'h0, SEL_SUB});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(3);

    // r0 writes are dropped and r0 is never forwarded.
    issue(SEL_MOVB, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    issue(SEL_ADD,  5'd0, 5'd0, 5'd4, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0);
    chk("r0_alu_a", alu_a, 32'h0);
    idle(3);

    // Illegal op sets the sticky flag and does not write r5.
    issue(5'b01111, 5'd1, 5'd0, 5'd5, 32'd99, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("illegal_err", {31'h0, err_illegal}, 32'h1);
    idle(3);
    issue(SEL_MOVB, 5'd0, 5'd5, 5'd6, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    idle(3);
    chk("illegal_err_sticky", {31'h0, err_illegal}, 32'h1);

    // Reset while a writeback is live discards it.
    issue(SEL_MOVB, 5'd0, 5'd0, 5'd7, 32'd9, 1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("pre_rst_wb_valid", {31'h0, wb_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_mid_alu_valid", {31'h0, alu_valid}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_err", {31'h0, err_illegal}, 32'h0);
    issue(SEL_MOVB, 5'd0, 5'd7, 5'd8, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    idle(4);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
